// File: rtl/rom_adder_display_pkg.sv
// Shared definitions for the ROM adder display: FSM encoding, BCD sizing and the
// active-low seven-segment font.
package rom_adder_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Three nibbles cover the largest sum, 63 + 63 = 126.
    localparam int BCD_NIBBLES = 3;
    localparam int BCD_W       = 4 * BCD_NIBBLES;

    // Segment order {g,f,e,d,c,b,a}, a zero lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rom_adder_display_scanner.sv
// Multiplexed seven-segment scanner: refresh divider, digit rotation, leading-zero
// blanking and overflow dashes. SEG and AN are registered together.
module seg7_scanner
    import rom_adder_display_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic [BCD_W-1:0] disp_bcd,
    output logic             OVF,
    output logic [6:0]       SEG,
    output logic [7:0]       AN
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]       cnt_reg;
    logic [2:0]             idx_reg;
    logic [6:0]             seg_reg, seg_next;
    logic [7:0]             an_reg, an_next;
    logic [31:0]            bcd_ext;
    logic [6:0]             digit_seg [8];
    logic [BCD_NIBBLES-1:0] ovf_bits;

    assign bcd_ext = {{(32-BCD_W){1'b0}}, disp_bcd};

    // Any nonzero nibble that has no digit position to live in means overflow.
    for (genvar gi = 0; gi < BCD_NIBBLES; gi++) begin : g_ovf
        if (gi >= DIGITS) begin : g_hidden
            assign ovf_bits[gi] = |disp_bcd[4*gi +: 4];
        end else begin : g_shown
            assign ovf_bits[gi] = 1'b0;
        end
    end
    assign OVF = |ovf_bits;

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        logic hi_zero;
        assign hi_zero = (bcd_ext >> (4*gi)) == 32'd0;
        assign digit_seg[gi] = OVF                 ? SEG_DASH  :
                               (gi > 0 && hi_zero) ? SEG_BLANK :
                               seg_font(bcd_ext[4*gi +: 4]);
    end

    always_comb begin
        seg_next         = digit_seg[idx_reg];
        an_next          = 8'hFF;
        an_next[idx_reg] = 1'b0;
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            cnt_reg <= '0;
            idx_reg <= 3'd0;
            seg_reg <= SEG_BLANK;
            an_reg  <= 8'hFF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
            if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == 3'(DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign SEG = seg_reg;
    assign AN  = an_reg;

endmodule

// File: rtl/rom_adder_display.sv
// Switch adder board block: synchronised operands, ROM sum table, sequential
// double-dabble to BCD, and a multiplexed seven-segment display.
module rom_adder_display
    import rom_adder_display_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               CLK100MHZ,
    input  logic               RST,
    input  logic [2*WIDTH-1:0] SW,
    output logic [6:0]         SEG,
    output logic [7:0]         AN,
    output logic               OVF,
    output logic               BUSY
);

    localparam int SUM_W     = WIDTH + 1;
    localparam int SR_W      = BCD_W + SUM_W;
    localparam int ROM_DEPTH = 2 ** (2 * WIDTH);

    logic [2*WIDTH-1:0] sw_meta_reg, sw_s_reg, op_reg;
    logic [SUM_W-1:0]   rom [ROM_DEPTH];
    logic [SUM_W-1:0]   rom_q_reg;
    logic [SR_W-1:0]    sr_reg;
    logic [BCD_W-1:0]   disp_bcd_reg;
    logic [3:0]         iter_reg;
    logic               lookup_ready_reg;
    logic               busy_reg;
    state_t             state_reg;

    // Address is {B,A}; each entry holds A + B.
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = SUM_W'(gi % (2 ** WIDTH)) + SUM_W'(gi / (2 ** WIDTH));
    end

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int i = 0; i < BCD_NIBBLES; i++) begin
            if (t[SUM_W+4*i +: 4] >= 4'd5)
                t[SUM_W+4*i +: 4] = t[SUM_W+4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            sw_meta_reg <= '0;
            sw_s_reg    <= '0;
            rom_q_reg   <= '0;
        end else begin
            sw_meta_reg <= SW;
            sw_s_reg    <= sw_meta_reg;
            rom_q_reg   <= rom[op_reg];
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state_reg        <= ST_IDLE;
            op_reg           <= '0;
            sr_reg           <= '0;
            disp_bcd_reg     <= '0;
            iter_reg         <= 4'd0;
            lookup_ready_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sw_s_reg != op_reg) begin
                        op_reg           <= sw_s_reg;
                        lookup_ready_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                        state_reg        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // First cycle lets the registered ROM read settle on the new op.
                    if (!lookup_ready_reg) begin
                        lookup_ready_reg <= 1'b1;
                    end else begin
                        sr_reg    <= {{BCD_W{1'b0}}, rom_q_reg};
                        iter_reg  <= 4'd0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr_reg   <= dabble_step(sr_reg);
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'(WIDTH))
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    disp_bcd_reg <= sr_reg[SR_W-1 -: BCD_W];
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = busy_reg;

    seg7_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scanner (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
        .disp_bcd  (disp_bcd_reg),
        .OVF       (OVF),
        .SEG       (SEG),
        .AN        (AN)
    );

endmodule

// File: tb/tb_rom_adder_display.sv
// Bench for rom_adder_display: three instances (DIGITS = 2, 1, 3) share switches and
// reset; a decimal-arithmetic model predicts every output each cycle.
module tb_rom_adder_display;

    localparam int WIDTH       = 4;
    localparam int REFRESH_DIV = 4;
    localparam int NDUT        = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;

    logic [6:0] seg  [NDUT];
    logic [7:0] an   [NDUT];
    logic       ovf  [NDUT];
    logic       busy [NDUT];

    int checks = 0;
    int errors = 0;

    function automatic int digs(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        rom_adder_display #(
            .WIDTH       (WIDTH),
            .DIGITS      ((gi == 0) ? 2 : (gi == 1) ? 1 : 3),
            .REFRESH_DIV (REFRESH_DIV)
        ) dut (
            .CLK100MHZ (clk),
            .RST       (rst),
            .SW        (sw),
            .SEG       (seg[gi]),
            .AN        (an[gi]),
            .OVF       (ovf[gi]),
            .BUSY      (busy[gi])
        );
    end

    always #5 clk = ~clk;

    function automatic logic [6:0] font(input int x);
        case (x)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    // What digit k of a D-digit display must show for decimal value v.
    function automatic logic [6:0] render(input int v, input int d, input int k);
        if (v >= pow10(d)) return 7'b0111111;
        if (k > 0 && v < pow10(k)) return 7'b1111111;
        return font((v / pow10(k)) % 10);
    endfunction

    // Model: converter reduced to "sum appears WIDTH+4 edges after capture".
    int         n_edge   = 0;
    logic [7:0] s1 = 8'h00, s2 = 8'h00, op = 8'h00;
    int         busy_cnt = 0;
    int         pending  = 0;
    int         shown    = 0;
    logic [6:0] exp_seg [NDUT] = '{7'h7F, 7'h7F, 7'h7F};
    logic [7:0] exp_an  [NDUT] = '{8'hFF, 8'hFF, 8'hFF};

    initial forever begin
        @(posedge clk);
        if (rst) begin
            n_edge = 0; s1 = 8'h00; s2 = 8'h00; op = 8'h00;
            busy_cnt = 0; pending = 0; shown = 0;
            for (int d = 0; d < NDUT; d++) begin
                exp_seg[d] = 7'h7F;
                exp_an[d]  = 8'hFF;
            end
        end else begin
            n_edge++;
            for (int d = 0; d < NDUT; d++) begin
                int         k;
                logic [7:0] m;
                k          = ((n_edge - 1) / REFRESH_DIV) % digs(d);
                m          = 8'd1 << k;
                exp_an[d]  = ~m;
                exp_seg[d] = render(shown, digs(d), k);
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) shown = pending;
            end else if (s2 != op) begin
                op       = s2;
                pending  = int'(op[3:0]) + int'(op[7:4]);
                busy_cnt = WIDTH + 4;
            end
            s2 = s1;
            s1 = sw;
        end
    end

    task automatic expect_eq(input string nm, input int d, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, want %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                expect_eq("rst_seg", d, 32'(seg[d]), 32'h7F);
                expect_eq("rst_an", d, 32'(an[d]), 32'hFF);
                expect_eq("rst_ovf", d, 32'(ovf[d]), 32'd0);
                expect_eq("rst_busy", d, 32'(busy[d]), 32'd0);
            end else begin
                expect_eq("seg", d, 32'(seg[d]), 32'(exp_seg[d]));
                expect_eq("an", d, 32'(an[d]), 32'(exp_an[d]));
                expect_eq("ovf", d, 32'(ovf[d]), (shown >= pow10(digs(d))) ? 32'd1 : 32'd0);
                expect_eq("busy", d, 32'(busy[d]), (busy_cnt > 0) ? 32'd1 : 32'd0);
            end
        end
    end

    task automatic wait_busy(input int d, input logic lvl, input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy[d] === lvl) break;
        end
        expect_eq(nm, d, 32'(busy[d]), 32'(lvl));
    endtask

    task automatic scan_expect(input int d, input logic [6:0] s_lo, input logic [6:0] s_hi);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (an[d] == 8'hFE) begin
                expect_eq("scan_d0", d, 32'(seg[d]), 32'(s_lo));
            end else begin
                expect_eq("scan_an", d, 32'(an[d]), 32'hFD);
                expect_eq("scan_d1", d, 32'(seg[d]), 32'(s_hi));
            end
        end
    endtask

    function automatic logic [7:0] next_an3(input logic [7:0] a);
        case (a)
            8'hFE:   return 8'hFD;
            8'hFD:   return 8'hFB;
            8'hFB:   return 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        int         nb;
        logic [7:0] cur;

        // Reset and idle display
        repeat (3) @(negedge clk);
        expect_eq("hand_rst_seg", 0, 32'(seg[0]), 32'h7F);
        expect_eq("hand_rst_an", 0, 32'(an[0]), 32'hFF);
        #1 rst = 1'b0;
        $display("txn: release reset, SW=00");
        repeat (20) @(negedge clk);
        expect_eq("idle_busy", 0, 32'(busy[0]), 32'd0);
        scan_expect(0, 7'b1000000, 7'b1111111);

        // 9 + 7 = 16, BUSY exactly 8 cycles
        #1 sw = 8'h79;
        $display("txn: A=9 B=7");
        wait_busy(0, 1'b1, 6, "busy_rise");
        nb = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy[0] !== 1'b1) break;
            nb++;
        end
        expect_eq("busy_len", 0, 32'(nb), 32'd8);
        repeat (16) @(negedge clk);
        scan_expect(0, 7'b0000010, 7'b1111001);
        scan_expect(1, 7'b0111111, 7'b0111111);

        // 9 + 9 = 18 overflows one digit only
        #1 sw = 8'h99;
        $display("txn: A=9 B=9");
        repeat (30) @(negedge clk);
        expect_eq("ovf_d1", 1, 32'(ovf[1]), 32'd1);
        expect_eq("ovf_d2", 0, 32'(ovf[0]), 32'd0);
        scan_expect(1, 7'b0111111, 7'b0111111);

        // 2 + 3 = 5 clears overflow
        #1 sw = 8'h32;
        $display("txn: A=2 B=3");
        repeat (30) @(negedge clk);
        expect_eq("ovf_clear", 1, 32'(ovf[1]), 32'd0);
        scan_expect(1, 7'b0010010, 7'b0010010);
        scan_expect(0, 7'b0010010, 7'b1111111);

        // 1 + 1, then 15 + 15 arriving while busy
        #1 sw = 8'h11;
        $display("txn: A=1 B=1 then A=15 B=15 mid-conversion");
        wait_busy(0, 1'b1, 6, "busy_rise2");
        repeat (4) @(negedge clk);
        #1 sw = 8'hFF;
        wait_busy(0, 1'b0, 12, "busy_fall2");
        @(negedge clk);
        expect_eq("busy_restart", 0, 32'(busy[0]), 32'd1);
        wait_busy(0, 1'b0, 12, "busy_fall3");
        repeat (16) @(negedge clk);
        scan_expect(0, 7'b1000000, 7'b0110000);

        // Reset during SHIFT with 5 + 5 pending
        #1 sw = 8'h55;
        $display("txn: A=5 B=5 with reset during shift");
        wait_busy(0, 1'b1, 6, "busy_rise4");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            expect_eq("async_seg", d, 32'(seg[d]), 32'h7F);
            expect_eq("async_an", d, 32'(an[d]), 32'hFF);
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        wait_busy(0, 1'b1, 4, "busy_after_rst");
        wait_busy(0, 1'b0, 12, "busy_fall5");
        repeat (16) @(negedge clk);
        scan_expect(0, 7'b1000000, 7'b1111001);

        // Three-digit rotation: 30 slots of 4 cycles each
        $display("txn: 3-digit scan, 30 slots");
        cur = an[2];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (an[2] != cur) break;
        end
        for (int slot = 0; slot < 30; slot++) begin
            int len;
            cur = an[2];
            len = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                len++;
                expect_eq("an_high_off", 2, 32'(an[2][7:3]), 32'h1F);
                if (an[2] != cur) break;
            end
            expect_eq("slot_len", 2, 32'(len), 32'd4);
            expect_eq("slot_next", 2, 32'(an[2]), 32'(next_an3(cur)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
